pc_ras_unit: RTL and testbench

//  Parametrised program-counter unit for the MIPS cores (single-cycle and pipelined builds).
//  - Holds the PC and computes next-PC for: sequential, BEQ/BNE, J/JAL, JR, exception entry.
//  - Adds a return-address stack (RAS): JAL pushes its link, JR $31 pops.
//  - Drives the instruction-memory word address and the branch/redirect status to control.

---
 rtl/mips_pkg.sv | 16 +
 rtl/ras_stack.sv | 60 ++++++
 rtl/pc_ras_unit.sv | 94 +++++++++
 tb/tb_pc_ras_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and the next-PC select encoding for the MIPS cores.
package mips_pkg;

    localparam int          ADDR_W_DEF    = 32;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_0080;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_J,
        SEL_JR,
        SEL_EXC
    } pc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address LIFO: a push when full silently overwrites the oldest entry.
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         valid,
    output logic         full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d, top_idx;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    // ptr_q is the next free slot; the top lives one below it.
    assign top_idx = ptr_q - PTR_W'(1);
    assign top     = mem_q[top_idx];
    assign valid   = (count_q != '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop & valid;

    always_comb begin
        mem_d   = mem_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        if (push && do_pop) begin
            mem_d[top_idx] = push_data;
        end else if (push) begin
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_q + PTR_W'(1);
            if (!full) count_d = count_q + CNT_W'(1);
        end else if (do_pop) begin
            ptr_d   = top_idx;
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/pc_ras_unit.sv
// Program counter with next-PC selection (branch, jump, register jump, exception)
// and a return-address stack fed by JAL and drained by JR $31.
module pc_ras_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                IMEM_AW   = 10,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(EXC_VEC_DEF),
    parameter int                RAS_DEPTH = 4,
    parameter bit                USE_RAS   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               exc_req,
    input  logic               Beq,
    input  logic               Bne,
    input  logic               AluEqual,
    input  logic               JMP,
    input  logic               JR,
    input  logic               JAL,
    input  logic               jr_ret,
    input  logic [ADDR_W-1:0]  R1,
    input  logic [ADDR_W-1:0]  I_imm,
    input  logic [25:0]        J_imm,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  normal_pc,
    output logic [IMEM_AW-1:0] addr,
    output logic               branch,
    output logic               ras_valid,
    output logic               ras_mismatch,
    output logic               misaligned
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] br_target, j_target, jr_target, next_pc, ras_top;
    logic              ras_full, ras_push, ras_pop, use_top;
    pc_sel_e           sel;

    assign pc        = pc_q;
    assign normal_pc = pc_q + ADDR_W'(4);
    assign addr      = pc_q[IMEM_AW+1:2];
    assign branch    = (Beq & AluEqual) | (Bne & ~AluEqual);

    assign br_target = normal_pc + (I_imm << 2);
    assign j_target  = {normal_pc[ADDR_W-1:28], J_imm, 2'b00};
    assign use_top   = USE_RAS & jr_ret & ras_valid;
    assign jr_target = use_top ? ras_top : R1;

    assign ras_mismatch = jr_ret & ras_valid & (ras_top != R1);
    assign misaligned   = JR & (jr_target[1:0] != 2'b00);

    // The stack only moves on edges that actually retire a non-exception instruction.
    assign ras_push = enable & ~exc_req & JAL;
    assign ras_pop  = enable & ~exc_req & jr_ret;

    always_comb begin
        sel = SEL_SEQ;
        if (exc_req)     sel = SEL_EXC;
        else if (JMP)    sel = JR ? SEL_JR : SEL_J;
        else if (branch) sel = SEL_BR;

        case (sel)
            SEL_EXC: next_pc = EXC_VEC;
            SEL_JR:  next_pc = jr_target;
            SEL_J:   next_pc = j_target;
            SEL_BR:  next_pc = br_target;
            default: next_pc = normal_pc;
        endcase

        pc_d = enable ? next_pc : pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_VEC;
        else     pc_q <= pc_d;
    end

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_W)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (normal_pc),
        .top       (ras_top),
        .valid     (ras_valid),
        .full      (ras_full)
    );

endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed bench for pc_ras_unit: one instance with the RAS target path, one without.
module tb_pc_ras_unit;
    logic        clk = 1'b0;
    logic        rst, enable, exc_req, Beq, Bne, AluEqual, JMP, JR, JAL, jr_ret;
    logic [31:0] R1, I_imm;
    logic [25:0] J_imm;

    logic [31:0] pc0, npc0, pc1, npc1;
    logic [9:0]  addr0, addr1;
    logic        br0, rv0, mm0, mis0, br1, rv1, mm1, mis1;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_link;

    always #5 clk = ~clk;

    pc_ras_unit u_dut (
        .clk(clk), .rst(rst), .enable(enable), .exc_req(exc_req), .Beq(Beq), .Bne(Bne),
        .AluEqual(AluEqual), .JMP(JMP), .JR(JR), .JAL(JAL), .jr_ret(jr_ret), .R1(R1),
        .I_imm(I_imm), .J_imm(J_imm), .pc(pc0), .normal_pc(npc0), .addr(addr0),
        .branch(br0), .ras_valid(rv0), .ras_mismatch(mm0), .misaligned(mis0)
    );

    pc_ras_unit #(.USE_RAS(1'b0)) u_noras (
        .clk(clk), .rst(rst), .enable(enable), .exc_req(exc_req), .Beq(Beq), .Bne(Bne),
        .AluEqual(AluEqual), .JMP(JMP), .JR(JR), .JAL(JAL), .jr_ret(jr_ret), .R1(R1),
        .I_imm(I_imm), .J_imm(J_imm), .pc(pc1), .normal_pc(npc1), .addr(addr1),
        .branch(br1), .ras_valid(rv1), .ras_mismatch(mm1), .misaligned(mis1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic clear_in();
        enable = 1'b1; exc_req = 1'b0; Beq = 1'b0; Bne = 1'b0; AluEqual = 1'b0;
        JMP = 1'b0; JR = 1'b0; JAL = 1'b0; jr_ret = 1'b0;
        R1 = '0; I_imm = '0; J_imm = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clear_in();
    endtask

    task automatic jump_to(input logic [31:0] tgt, input logic link);
        JMP = 1'b1; JAL = link; J_imm = tgt[27:2];
        step();
    endtask

    task automatic ret(input logic [31:0] r1v);
        JMP = 1'b1; JR = 1'b1; jr_ret = 1'b1; R1 = r1v;
        #1;
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        step();
        step();
        check("rst_pc", pc0, 32'h0);
        check("rst_addr", {22'h0, addr0}, 32'h0);
        check("rst_ras_valid", {31'h0, rv0}, 32'h0);
        check("rst_normal_pc", npc0, 32'h4);
        rst = 1'b0;
        step(); check("seq_pc_4", pc0, 32'h4);
        step(); check("seq_pc_8", pc0, 32'h8);
        step(); check("seq_pc_c", pc0, 32'hC);
        check("seq_addr_3", {22'h0, addr0}, 32'h3);

        // Conditional branches
        jump_to(32'h40, 1'b0);
        check("jump_pc_40", pc0, 32'h40);
        Beq = 1'b1; AluEqual = 1'b1; I_imm = 32'hFFFF_FFFE; #1;
        check("beq_taken_flag", {31'h0, br0}, 32'h1);
        step(); check("beq_taken_pc", pc0, 32'h3C);
        jump_to(32'h40, 1'b0);
        Beq = 1'b1; AluEqual = 1'b0; I_imm = 32'hFFFF_FFFE; #1;
        check("beq_not_flag", {31'h0, br0}, 32'h0);
        step(); check("beq_not_pc", pc0, 32'h44);
        Bne = 1'b1; AluEqual = 1'b0; I_imm = 32'h4; #1;
        check("bne_taken_flag", {31'h0, br0}, 32'h1);
        step(); check("bne_taken_pc", pc0, 32'h58);

        // JAL / return pair
        jump_to(32'h100, 1'b0);
        jump_to(32'h100, 1'b1);
        check("jal_pc", pc0, 32'h100);
        check("jal_ras_valid", {31'h0, rv0}, 32'h1);
        ret(32'h104);
        check("ret_no_mismatch", {31'h0, mm0}, 32'h0);
        step();
        check("ret_pc", pc0, 32'h104);
        check("ret_ras_empty", {31'h0, rv0}, 32'h0);

        // Overflow: five calls into a four-deep stack, then drain past empty
        for (int i = 1; i <= 5; i++) begin
            exp_link = pc0 + 32'h4;
            exp_q.push_back(exp_link);
            if (exp_q.size() > 4) void'(exp_q.pop_front());
            jump_to(32'h1000 * i, 1'b1);
            check("call_pc", pc0, 32'h1000 * i);
        end
        for (int i = 0; i < 4; i++) begin
            ret(32'h200);
            exp_link = exp_q.pop_back();
            step();
            check("ras_ret_pc", pc0, exp_link);
            check("noras_ret_pc", pc1, 32'h200);
        end
        check("drained_valid", {31'h0, rv0}, 32'h0);
        ret(32'h200);
        check("empty_no_mismatch", {31'h0, mm0}, 32'h0);
        step();
        check("empty_ret_pc", pc0, 32'h200);

        // Stall and exception leave the stack alone
        jump_to(32'h300, 1'b0);
        jump_to(32'h100, 1'b1);
        enable = 1'b0; exc_req = 1'b1; JMP = 1'b1; JAL = 1'b1; J_imm = 26'h123;
        step();
        check("stall_pc", pc0, 32'h100);
        exc_req = 1'b1; JMP = 1'b1; J_imm = 26'h123;
        step();
        check("exc_pc", pc0, 32'h80);
        check("exc_ras_valid", {31'h0, rv0}, 32'h1);
        ret(32'h304);
        check("exc_ras_no_mismatch", {31'h0, mm0}, 32'h0);
        step();
        check("exc_ras_ret_pc", pc0, 32'h304);
        check("exc_ras_single", {31'h0, rv0}, 32'h0);

        // Mismatch, USE_RAS=0 fallback, misalignment
        jump_to(32'h100, 1'b0);
        jump_to(32'h100, 1'b1);
        ret(32'h108);
        check("mismatch_flag", {31'h0, mm0}, 32'h1);
        check("mismatch_aligned", {31'h0, mis0}, 32'h0);
        step();
        check("mismatch_ras_pc", pc0, 32'h104);
        check("mismatch_noras_pc", pc1, 32'h108);
        JMP = 1'b1; JR = 1'b1; R1 = 32'h10A; #1;
        check("misaligned_flag", {31'h0, mis0}, 32'h1);
        step();
        check("misaligned_pc", pc0, 32'h10A);

        // Silent wrap of the sequential add
        JMP = 1'b1; JR = 1'b1; R1 = 32'hFFFF_FFFC;
        step();
        check("top_pc", pc0, 32'hFFFF_FFFC);
        check("wrap_normal_pc", npc0, 32'h0);
        step();
        check("wrap_pc", pc0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
